// File: rtl/rr_bus_interconnect.sv
// rr_bus_interconnect: round-robin multi-master bus interconnect.
// The interconnect serves one transaction at a time using three states: IDLE -> ISSUE -> WAIT.
// Each master's address is decoded against base/end windows. The lowest matching window wins.
// The response is registered and shown to the master for one cycle.
module rr_bus_interconnect #(
  parameter int WIDTH   = 32,
  parameter int REGIONS = 5,
  parameter int MASTERS = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [MASTERS-1:0]         req_m,
  input  logic [MASTERS-1:0]         we_m,
  input  logic [MASTERS*WIDTH-1:0]   addr_m,
  input  logic [MASTERS*WIDTH-1:0]   wd_m,
  output logic [MASTERS-1:0]         gnt_m,
  output logic [MASTERS-1:0]         rvalid_m,
  output logic [MASTERS-1:0]         err_m,
  output logic [WIDTH-1:0]           rd_m,
  input  logic [REGIONS*WIDTH-1:0]   region_base,
  input  logic [REGIONS*WIDTH-1:0]   region_end,
  input  logic [REGIONS*WIDTH-1:0]   rd_s,
  output logic [REGIONS-1:0]         we_s,
  output logic [REGIONS*WIDTH-1:0]   addr_s,
  output logic [REGIONS*WIDTH-1:0]   wd_s
);

  localparam int MW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int RW = (REGIONS > 1) ? $clog2(REGIONS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t               state_q, state_d;
  logic [MW-1:0]        ptr_q, ptr_d;
  logic [MW-1:0]        idx_q, idx_d;
  logic                 we_q, we_d;
  logic                 hit_q, hit_d;
  logic [RW-1:0]        region_q, region_d;
  logic [WIDTH-1:0]     addr_q, addr_d;
  logic [WIDTH-1:0]     wd_q, wd_d;
  logic [WIDTH-1:0]     rd_q, rd_d;
  logic [MASTERS-1:0]   rvalid_q, rvalid_d;
  logic [MASTERS-1:0]   err_q, err_d;

  logic                 any_req;
  logic [MW-1:0]        win_idx;
  logic                 win_we;
  logic [WIDTH-1:0]     win_addr;
  logic [WIDTH-1:0]     win_wd;
  logic                 dec_hit;
  logic [RW-1:0]        dec_region;

  // Pick the first requester. The scan starts just after the last master that was served.
  always_comb begin
    any_req  = 1'b0;
    win_idx  = '0;
    win_we   = 1'b0;
    win_addr = '0;
    win_wd   = '0;
    for (int i = 1; i <= MASTERS; i++) begin
      for (int m = 0; m < MASTERS; m++) begin
        if (!any_req && req_m[m] && (m == (int'(ptr_q) + i) % MASTERS)) begin
          any_req  = 1'b1;
          win_idx  = MW'(m);
          win_we   = we_m[m];
          win_addr = addr_m[m*WIDTH +: WIDTH];
          win_wd   = wd_m[m*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Find the window that contains the winner's address. The lowest index wins, and base==end never matches.
  always_comb begin
    dec_hit    = 1'b0;
    dec_region = '0;
    for (int r = 0; r < REGIONS; r++) begin
      if (!dec_hit &&
          (win_addr >= region_base[r*WIDTH +: WIDTH]) &&
          (win_addr <  region_end[r*WIDTH +: WIDTH])) begin
        dec_hit    = 1'b1;
        dec_region = RW'(r);
      end
    end
  end

  // Compute the next state and drive the grant and slave-side outputs for the current state.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    we_d     = we_q;
    hit_d    = hit_q;
    region_d = region_q;
    addr_d   = addr_q;
    wd_d     = wd_q;
    rd_d     = rd_q;
    rvalid_d = '0;
    err_d    = '0;
    gnt_m    = '0;
    we_s     = '0;
    addr_s   = '0;
    wd_s     = '0;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          idx_d    = win_idx;
          we_d     = win_we;
          addr_d   = win_addr;
          wd_d     = win_wd;
          hit_d    = dec_hit;
          region_d = dec_region;
          ptr_d    = win_idx;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        for (int m = 0; m < MASTERS; m++) begin
          if (idx_q == MW'(m)) gnt_m[m] = 1'b1;
        end
        for (int r = 0; r < REGIONS; r++) begin
          if (hit_q && (region_q == RW'(r))) begin
            we_s[r]                  = we_q;
            addr_s[r*WIDTH +: WIDTH] = addr_q - region_base[r*WIDTH +: WIDTH];
            wd_s[r*WIDTH +: WIDTH]   = wd_q;
          end
        end
        state_d = S_WAIT;
      end
      S_WAIT: begin
        for (int m = 0; m < MASTERS; m++) begin
          if (idx_q == MW'(m)) begin
            rvalid_d[m] = 1'b1;
            err_d[m]    = !hit_q;
          end
        end
        rd_d = '0;
        for (int r = 0; r < REGIONS; r++) begin
          if (hit_q && !we_q && (region_q == RW'(r))) rd_d = rd_s[r*WIDTH +: WIDTH];
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registers for the state, the arbitration pointer, the latched transaction and the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= MW'(MASTERS - 1);
      idx_q    <= '0;
      we_q     <= 1'b0;
      hit_q    <= 1'b0;
      region_q <= '0;
      addr_q   <= '0;
      wd_q     <= '0;
      rd_q     <= '0;
      rvalid_q <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      we_q     <= we_d;
      hit_q    <= hit_d;
      region_q <= region_d;
      addr_q   <= addr_d;
      wd_q     <= wd_d;
      rd_q     <= rd_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  assign rvalid_m = rvalid_q;
  assign err_m    = err_q;
  assign rd_m     = rd_q;

endmodule

// File: tb/tb_rr_bus_interconnect.sv
// tb_rr_bus_interconnect: self-checking bench for the round-robin interconnect.
// A transaction-level model predicts the arbitration winner, the region decode, the slave-side
// outputs and the response. The bench's slave returns (offset ^ per-region salt) one cycle later.
module tb_rr_bus_interconnect;

  localparam int W = 32;
  localparam int R = 5;
  localparam int M = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [M-1:0]       req_m, we_m;
  logic [M*W-1:0]     addr_m, wd_m;
  logic [M-1:0]       gnt_m, rvalid_m, err_m;
  logic [W-1:0]       rd_m;
  logic [R*W-1:0]     region_base, region_end, rd_s;
  logic [R-1:0]       we_s;
  logic [R*W-1:0]     addr_s, wd_s;

  int checks = 0;
  int failures = 0;
  int model_ptr;
  logic [W-1:0] last_rd;

  rr_bus_interconnect #(.WIDTH(W), .REGIONS(R), .MASTERS(M)) dut (
    .clk(clk), .rst(rst), .req_m(req_m), .we_m(we_m), .addr_m(addr_m), .wd_m(wd_m),
    .gnt_m(gnt_m), .rvalid_m(rvalid_m), .err_m(err_m), .rd_m(rd_m),
    .region_base(region_base), .region_end(region_end), .rd_s(rd_s),
    .we_s(we_s), .addr_s(addr_s), .wd_s(wd_s)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] salt(input int r);
    return 32'hA5A5_0000 + W'(r) * 32'h0000_1111;
  endfunction

  // Synchronous slave model: read data follows the presented address one cycle later.
  always @(posedge clk) begin
    for (int r = 0; r < R; r++) rd_s[r*W +: W] <= addr_s[r*W +: W] ^ salt(r);
  end

  function automatic logic [W-1:0] baseOf(input int r);
    return region_base[r*W +: W];
  endfunction

  function automatic logic [W-1:0] endOf(input int r);
    return region_end[r*W +: W];
  endfunction

  task automatic setRegion(input int r, input logic [W-1:0] b, input logic [W-1:0] e);
    region_base[r*W +: W] = b;
    region_end[r*W +: W]  = e;
  endtask

  task automatic applyStimulus(input logic [M-1:0] req, input logic [M-1:0] we,
                               input logic [M*W-1:0] addr, input logic [M*W-1:0] wd);
    req_m  = req;
    we_m   = we;
    addr_m = addr;
    wd_m   = wd;
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic driveGarbage();
    logic [M*W-1:0] a, d;
    for (int m = 0; m < M; m++) begin
      a[m*W +: W] = $urandom;
      d[m*W +: W] = $urandom;
    end
    applyStimulus(M'($urandom), M'($urandom), a, d);
  endtask

  // Run one full transaction, starting at an IDLE cycle and ending at the response cycle.
  task automatic runTxn(input logic [M-1:0] req, input logic [M-1:0] we,
                        input logic [M*W-1:0] addr, input logic [M*W-1:0] wd);
    int w, hit_r;
    logic [W-1:0] a, d, off, exp_rd;
    logic is_wr;
    logic [M-1:0] onehot, exp_err;
    logic [R-1:0] exp_we;
    logic [R*W-1:0] exp_addr, exp_wd;
    if (req == '0) req = 1;
    applyStimulus(req, we, addr, wd);
    w = -1;
    for (int k = 1; k <= M; k++) begin
      int c;
      c = (model_ptr + k) % M;
      if (w < 0 && req[c]) w = c;
    end
    model_ptr = w;
    a = addr[w*W +: W];
    d = wd[w*W +: W];
    is_wr = we[w];
    hit_r = -1;
    for (int r = 0; r < R; r++)
      if (hit_r < 0 && a >= baseOf(r) && a < endOf(r)) hit_r = r;
    onehot = '0;
    onehot[w] = 1'b1;
    exp_we = '0;
    exp_addr = '0;
    exp_wd = '0;
    exp_rd = '0;
    exp_err = onehot;
    if (hit_r >= 0) begin
      off = a - baseOf(hit_r);
      exp_we[hit_r] = is_wr;
      exp_addr[hit_r*W +: W] = off;
      exp_wd[hit_r*W +: W] = d;
      exp_rd = is_wr ? '0 : (off ^ salt(hit_r));
      exp_err = '0;
    end
    @(negedge clk);
    driveGarbage();
    #1;
    checkOutput("issue_gnt", gnt_m, onehot);
    checkOutput("issue_we_s", we_s, exp_we);
    checkOutput("issue_addr_s", addr_s, exp_addr);
    checkOutput("issue_wd_s", wd_s, exp_wd);
    checkOutput("issue_rvalid", rvalid_m, 0);
    checkOutput("issue_rd_hold", rd_m, last_rd);
    @(negedge clk);
    driveGarbage();
    #1;
    checkOutput("wait_gnt", gnt_m, 0);
    checkOutput("wait_we_s", we_s, 0);
    checkOutput("wait_addr_s", addr_s, 0);
    checkOutput("wait_rd_hold", rd_m, last_rd);
    @(negedge clk);
    #1;
    checkOutput("resp_rvalid", rvalid_m, onehot);
    checkOutput("resp_err", err_m, exp_err);
    checkOutput("resp_rd", rd_m, exp_rd);
    last_rd = exp_rd;
  endtask

  function automatic logic [W-1:0] pickAddr();
    int r;
    logic [W-1:0] b, e;
    r = $urandom_range(0, R - 1);
    b = baseOf(r);
    e = endOf(r);
    case ($urandom_range(0, 3))
      0:       return (e > b) ? b + ($urandom % (e - b)) : b;
      1:       return $urandom;
      2:       return e;
      default: return e - 1;
    endcase
  endfunction

  task automatic randomPhase(input int n);
    logic [M*W-1:0] a, d;
    for (int t = 0; t < n; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        applyStimulus('0, '0, '0, '0);
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          #1;
          checkOutput("idle_gnt", gnt_m, 0);
          checkOutput("idle_rvalid", rvalid_m, 0);
        end
      end
      for (int m = 0; m < M; m++) begin
        a[m*W +: W] = pickAddr();
        d[m*W +: W] = $urandom;
      end
      runTxn(M'($urandom_range(1, (1 << M) - 1)), M'($urandom), a, d);
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus('0, '0, '0, '0);
    setRegion(0, 32'h0001_0000, 32'h0002_0000);
    setRegion(1, 32'h0000_0100, 32'h0000_0200);
    setRegion(2, 32'h0002_0000, 32'h0003_0000);
    setRegion(3, 32'h0000_0300, 32'h0000_0300);
    setRegion(4, 32'h4000_0000, 32'h4000_1000);
    model_ptr = M - 1;
    last_rd = '0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_gnt", gnt_m, 0);
    checkOutput("reset_rvalid", rvalid_m, 0);
    checkOutput("reset_err", err_m, 0);
    checkOutput("reset_rd", rd_m, 0);
    checkOutput("reset_we_s", we_s, 0);
    checkOutput("reset_addr_s", addr_s, 0);
    checkOutput("reset_wd_s", wd_s, 0);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #1;
      checkOutput("noreq_gnt", gnt_m, 0);
    end

    // Directed cases using the first region layout.
    runTxn(2'b01, 2'b00, {32'h0, 32'h0000_0104}, 64'h0);
    runTxn(2'b10, 2'b10, {32'h0000_0100, 32'h0}, {32'h0000_0055, 32'h0});
    runTxn(2'b01, 2'b00, {32'h0, 32'hFFFF_0000}, 64'h0);
    runTxn(2'b01, 2'b01, {32'h0, 32'hFFFF_0000}, {32'h0, 32'h1234_5678});
    runTxn(2'b10, 2'b00, {32'h0000_0300, 32'h0}, 64'h0);
    runTxn(2'b01, 2'b00, {32'h0, 32'h0000_01FF}, 64'h0);
    runTxn(2'b10, 2'b00, {32'h0000_0200, 32'h0}, 64'h0);
    repeat (4) runTxn(2'b11, 2'b00, {32'h0001_0040, 32'h0002_0080}, 64'h0);
    repeat (3) runTxn(2'b10, 2'b00, {32'h4000_0FFC, 32'h0}, 64'h0);
    randomPhase(25);

    // Overlapping layout: region 0 shadows regions 1 and 2 inside [0,0x1000).
    setRegion(0, 32'h0000_0000, 32'h0000_1000);
    setRegion(2, 32'h0000_0800, 32'h0000_0900);
    runTxn(2'b01, 2'b01, {32'h0, 32'h0000_0810}, {32'h0, 32'hCAFE_F00D});
    runTxn(2'b10, 2'b00, {32'h0000_0810, 32'h0}, 64'h0);
    randomPhase(25);

    // Reset arriving in WAIT drops the transaction and restarts arbitration at master 0.
    applyStimulus('0, '0, '0, '0);
    @(negedge clk);
    #1;
    applyStimulus(2'b01, 2'b00, {32'h0, 32'h0000_0104}, 64'h0);
    @(negedge clk);
    #1;
    checkOutput("rstw_issue_gnt", gnt_m, 2'b01);
    applyStimulus('0, '0, '0, '0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("rstw_gnt", gnt_m, 0);
    checkOutput("rstw_rvalid", rvalid_m, 0);
    checkOutput("rstw_err", err_m, 0);
    checkOutput("rstw_rd", rd_m, 0);
    checkOutput("rstw_we_s", we_s, 0);
    checkOutput("rstw_addr_s", addr_s, 0);
    rst = 1'b0;
    model_ptr = M - 1;
    last_rd = '0;
    repeat (2) begin
      @(negedge clk);
      #1;
      checkOutput("post_rst_rvalid", rvalid_m, 0);
      checkOutput("post_rst_gnt", gnt_m, 0);
    end
    runTxn(2'b11, 2'b00, {32'h0000_0010, 32'h0000_0020}, 64'h0);
    runTxn(2'b11, 2'b00, {32'h0000_0010, 32'h0000_0020}, 64'h0);
    applyStimulus('0, '0, '0, '0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
